// File: rtl/demux_1_n_stream.sv
// Purpose: registered 1-to-N stream demux with unicast, broadcast and dropping of out-of-range selects.
// Latency: a word accepted at a clock edge is visible on out_data/out_valid right after that edge.
// Backpressure: in_ready falls only when the addressed slot, or any slot for a broadcast, is full and not draining.
module demux_1_n_stream #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = $clog2(N_OUT),
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [CNT_W-1:0]        drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // One holding register per channel plus the drop counter
    logic [N_OUT-1:0][DATA_W-1:0] data_q, data_d;
    logic [N_OUT-1:0]             valid_q, valid_d;
    logic [CNT_W-1:0]             drop_q, drop_d;

    logic [N_OUT-1:0] free;
    logic             sel_in_range;
    logic             accept;

    // A slot can take a word if it is empty or its consumer is taking the current word
    assign free = ~valid_q | out_ready;

    // Selects past the last channel only exist when N_OUT is not a power of two
    assign sel_in_range = ({{(32-SEL_W){1'b0}}, in_sel} < 32'(N_OUT));

    // Ready depends only on the targeted slots; out-of-range words are always swallowed
    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &free;
        end else if (sel_in_range) begin
            in_ready = free[in_sel];
        end
    end

    assign accept = in_valid && in_ready;

    // Per-channel next state: a load wins over a simultaneous drain, data is kept on drain
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        for (int i = 0; i < N_OUT; i++) begin
            if (accept && (in_bcast || (sel_in_range && in_sel == SEL_W'(i)))) begin
                data_d[i]  = in_data;
                valid_d[i] = 1'b1;
            end else if (valid_q[i] && out_ready[i]) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    // Count words discarded for an out-of-range select, holding at the maximum
    always_comb begin
        drop_d = drop_q;
        if (accept && !in_bcast && !sel_in_range && drop_q != CNT_MAX) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // State registers; reset empties every slot and clears the payloads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= '0;
            drop_q  <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign drop_cnt  = drop_q;

endmodule

// File: doc/demux_1_n_stream.md
# demux_1_n_stream

Parametrised, registered 1-to-N stream demultiplexer with per-channel valid/ready handshake, broadcast mode and out-of-range select handling. It is the successor to the combinational 1-to-4 demux. It routes a DATA_W-bit word from a single producer to one of N_OUT (or all) consumers. Each output has a one-entry holding register so that a stalled consumer blocks only traffic addressed to it. It sits between a single-source datapath and multiple lab peripherals and sink FIFOs.

## Interface
Parameters:
- DATA_W, 8, payload width in bits (≥1)
- N_OUT, 4, number of output channels (2..16)
- SEL_W, $clog2(N_OUT), select width (derived, not overridden)
- CNT_W, 8, width of drop counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  DATA_W  input payload
- in_sel  in  SEL_W  destination channel index
- in_bcast  in  1  1 = deliver to all channels, in_sel ignored
- in_valid  in  1  producer has a word
- in_ready  out  1  block accepts word this cycle
- out_data  out  N_OUT*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W]
- out_valid  out  N_OUT  channel i holds a word
- out_ready  in  N_OUT  consumer i takes the word
- drop_cnt  out  CNT_W  count of words dropped for out-of-range select

## Operation
- Per channel i: state EMPTY (out_valid[i]=0) or FULL (out_valid[i]=1).
- free[i] = !out_valid[i] || out_ready[i] (slot empty or draining this cycle).
- in_ready is combinational:
  - in_bcast=1: AND of free[0..N_OUT-1].
  - in_bcast=0, in_sel < N_OUT: free[in_sel].
  - in_bcast=0, in_sel ≥ N_OUT (possible only when N_OUT is not a power of 2): 1.
- Accept = in_valid && in_ready, sampled at the rising edge.
- Unicast accept: out_data[in_sel] ← in_data and out_valid[in_sel] ← 1. Other channels are unchanged apart from their own drain.
- Broadcast accept: every channel loads in_data and sets out_valid.
- Drop: accept with an out-of-range select writes no channel, and drop_cnt increments. drop_cnt saturates at 2^CNT_W−1 and does not wrap.
- Drain: out_valid[i] && out_ready[i] with no new load into i → out_valid[i] ← 0. out_data[i] keeps its last value.
- A drain and a load on the same channel in the same edge is a load: valid stays 1 and data is replaced, giving one word per cycle per channel.
- in_data, in_sel and in_bcast are don't-care when in_valid=0. No state changes.
- out_ready[i] while out_valid[i]=0 is ignored.
- The producer must hold in_data, in_sel and in_bcast stable while in_valid=1 && in_ready=0. The block does not check this rule.

## Timing
- Reset (rst_n=0, asynchronous assert, release synchronised by the source): out_valid=0, out_data=0, drop_cnt=0. After reset in_ready = 1 for any unicast or broadcast, because all slots are EMPTY.
- Latency: a word accepted at edge k is visible on out_data/out_valid from edge k onward, i.e. one cycle after it was presented.
- Throughput: one word per cycle into any channel whose consumer holds out_ready=1.
- Stall isolation: a FULL channel j with out_ready[j]=0 blocks only words addressed to j and broadcasts. Unicast to other channels proceeds.
- Reset asserted mid-transfer discards all held words immediately. A pending word is not delivered.
- No combinational path from in_valid to out_valid. Combinational paths exist from out_ready to in_ready only.

## Test plan
- Reset then unicast 0xA5 to sel=2, all out_ready=1 -> out_valid=4'b0100 and out_data[2]=0xA5 one cycle later, then 0 the cycle after.
- Channel 1 held with out_ready[1]=0 after loading 0x11; offer sel=1 0x22 and sel=3 0x33 -> in_ready=0 for sel=1, sel=3 accepted, out_data[3]=0x33, channel 1 still 0x11 until out_ready[1]=1. The next cycle then loads 0x22.
- Back-to-back unicast 0x01..0x08 to sel=0 with out_ready[0]=1 every cycle -> in_ready stays 1 and the consumer sees 0x01..0x08 on consecutive cycles.
- Broadcast 0x5A with channel 2 stalled FULL -> in_ready=0 until channel 2 drains. Then all four channels show 0x5A and out_valid=4'b1111.
- N_OUT=3, sel=3, 300 accepted words, CNT_W=8 -> no out_valid set and drop_cnt saturates at 255.
- Assert rst_n=0 mid-stream with channels FULL -> out_valid=0, out_data=0 and drop_cnt=0 immediately, without waiting for a clock edge.
